// File: rtl/sdram_arbiter.sv
// Arbitrates a CPU byte port and a video word-read port onto one SDRAM controller, with periodic refresh.
// Define ARB_ROUND_ROBIN_EN to alternate CPU/video when both request; otherwise video always wins.
module sdram_arbiter #(
    parameter int REFRESH_CYCLES = 700
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        a_req,
    input  logic        a_we,
    input  logic [22:0] a_addr,
    input  logic [7:0]  a_din,
    output logic        a_ack,
    output logic [7:0]  a_dout,
    input  logic        b_req,
    input  logic [22:0] b_addr,
    output logic        b_ack,
    output logic [31:0] b_dout,
    output logic        sd_rd,
    output logic        sd_wr,
    output logic        sd_refresh,
    output logic [22:0] sd_addr,
    output logic [7:0]  sd_din,
    input  logic [7:0]  sd_dout,
    input  logic [31:0] sd_dout32,
    input  logic        sd_data_ready,
    input  logic        sd_busy
);
    // state     | meaning
    // IDLE      | waiting for controller free and a request or pending refresh
    // ISSUE     | one-cycle command pulse to the controller
    // WAIT_BUSY | waiting for the controller to accept (sd_busy rises)
    // WAIT_DONE | command running; capture read data, ack when sd_busy falls
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_REF, OWN_A, OWN_B} owner_t;

    localparam int CNT_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_CYCLES - 1);

    state_t           state, state_nxt;
    owner_t           owner;
    logic             we_q;
    logic [CNT_W-1:0] refresh_cnt;
    logic             refresh_pending;
    logic             refresh_wrap;
    logic             pick_b;
    logic             grant_ref, grant_a, grant_b;

    assign refresh_wrap = (refresh_cnt == CNT_LAST);

`ifdef ARB_ROUND_ROBIN_EN
    logic last_b;
    assign pick_b = b_req && (!a_req || !last_b);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            last_b <= 1'b0;
        end else if (grant_b) begin
            last_b <= 1'b1;
        end else if (grant_a) begin
            last_b <= 1'b0;
        end
    end
`else
    assign pick_b = b_req;
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        grant_ref  = 1'b0;
        grant_a    = 1'b0;
        grant_b    = 1'b0;
        sd_rd      = 1'b0;
        sd_wr      = 1'b0;
        sd_refresh = 1'b0;
        a_ack      = 1'b0;
        b_ack      = 1'b0;
        case (state)
            IDLE: begin
                if (!sd_busy) begin
                    if (refresh_pending) begin
                        grant_ref = 1'b1;
                    end else if (pick_b) begin
                        grant_b = 1'b1;
                    end else if (a_req) begin
                        grant_a = 1'b1;
                    end
                    if (grant_ref || grant_a || grant_b) begin
                        state_nxt = ISSUE;
                    end
                end
            end
            ISSUE: begin
                sd_refresh = (owner == OWN_REF);
                sd_wr      = (owner == OWN_A) && we_q;
                sd_rd      = (owner == OWN_B) || ((owner == OWN_A) && !we_q);
                state_nxt  = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (sd_busy) begin
                    state_nxt = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (!sd_busy) begin
                    a_ack     = (owner == OWN_A);
                    b_ack     = (owner == OWN_B);
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // Outputs stay quiet while reset is held, even before the reset edge lands.
        if (!resetn) begin
            sd_rd      = 1'b0;
            sd_wr      = 1'b0;
            sd_refresh = 1'b0;
            a_ack      = 1'b0;
            b_ack      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            refresh_cnt     <= '0;
            refresh_pending <= 1'b0;
            owner           <= OWN_NONE;
            we_q            <= 1'b0;
            sd_addr         <= '0;
            sd_din          <= '0;
            a_dout          <= '0;
            b_dout          <= '0;
        end else begin
            refresh_cnt <= refresh_wrap ? '0 : refresh_cnt + 1'b1;
            // A wrap wins over a coincident refresh grant, so the new interval is not lost.
            if (refresh_wrap) begin
                refresh_pending <= 1'b1;
            end else if (grant_ref) begin
                refresh_pending <= 1'b0;
            end
            if (grant_ref) begin
                owner <= OWN_REF;
            end
            if (grant_a) begin
                owner   <= OWN_A;
                we_q    <= a_we;
                sd_addr <= a_addr;
                sd_din  <= a_din;
            end
            if (grant_b) begin
                owner   <= OWN_B;
                we_q    <= 1'b0;
                sd_addr <= b_addr;
            end
            if (state == WAIT_DONE && sd_data_ready) begin
                if (owner == OWN_A && !we_q) begin
                    a_dout <= sd_dout;
                end
                if (owner == OWN_B) begin
                    b_dout <= sd_dout32;
                end
            end
        end
    end
endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter with a small SDRAM controller model (REFRESH_CYCLES=20).
module tb_sdram_arbiter;
    logic        clk = 1'b0;
    logic        resetn;
    logic        a_req, a_we;
    logic [22:0] a_addr;
    logic [7:0]  a_din;
    logic        a_ack;
    logic [7:0]  a_dout;
    logic        b_req;
    logic [22:0] b_addr;
    logic        b_ack;
    logic [31:0] b_dout;
    logic        sd_rd, sd_wr, sd_refresh;
    logic [22:0] sd_addr;
    logic [7:0]  sd_din;
    logic [7:0]  sd_dout;
    logic [31:0] sd_dout32;
    logic        sd_data_ready;
    logic        sd_busy;

    logic        ctl_force;
    logic [7:0]  mem8;
    logic [31:0] mem32;
    int          ctl_cnt;
    logic        ctl_rd;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sdram_arbiter #(.REFRESH_CYCLES(20)) dut (
        .clk(clk), .resetn(resetn),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_din(a_din),
        .a_ack(a_ack), .a_dout(a_dout),
        .b_req(b_req), .b_addr(b_addr), .b_ack(b_ack), .b_dout(b_dout),
        .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_refresh(sd_refresh),
        .sd_addr(sd_addr), .sd_din(sd_din),
        .sd_dout(sd_dout), .sd_dout32(sd_dout32),
        .sd_data_ready(sd_data_ready), .sd_busy(sd_busy)
    );

    // Controller model: busy for 4 cycles after a command, data_ready one cycle before busy drops.
    assign sd_busy   = ctl_force | (ctl_cnt != 0);
    assign sd_dout   = mem8;
    assign sd_dout32 = mem32;

    always @(posedge clk) begin
        if (!resetn) begin
            ctl_cnt       <= 0;
            ctl_rd        <= 1'b0;
            sd_data_ready <= 1'b0;
        end else if (sd_rd || sd_wr || sd_refresh) begin
            ctl_cnt       <= 4;
            ctl_rd        <= sd_rd;
            sd_data_ready <= 1'b0;
        end else if (ctl_cnt != 0) begin
            ctl_cnt       <= ctl_cnt - 1;
            sd_data_ready <= (ctl_cnt == 2) && ctl_rd;
        end else begin
            sd_data_ready <= 1'b0;
        end
    end

    int          n_ref = 0, n_rd = 0, n_wr = 0, viol = 0;
    int          cmd_log[$];
    logic [22:0] rw_addr = '0;
    logic [7:0]  wr_din = '0;
    int          last_rw_kind = 0;
    logic        prev_cmd = 1'b0, prev_a = 1'b0, prev_b = 1'b0;

    always @(negedge clk) begin
        if (resetn) begin
            if ($countones({sd_rd, sd_wr, sd_refresh}) > 1) viol++;
            if (prev_cmd && (sd_rd || sd_wr || sd_refresh)) viol++;
            if ((prev_a && a_ack) || (prev_b && b_ack)) viol++;
            if (sd_refresh) begin n_ref++; cmd_log.push_back(3); end
            if (sd_rd) begin n_rd++; cmd_log.push_back(1); rw_addr = sd_addr; last_rw_kind = 1; end
            if (sd_wr) begin n_wr++; cmd_log.push_back(2); rw_addr = sd_addr; wr_din = sd_din; last_rw_kind = 2; end
        end
        prev_cmd = sd_rd | sd_wr | sd_refresh;
        prev_a   = a_ack;
        prev_b   = b_ack;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic wait_ack(input bit port_b, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (port_b ? b_ack : a_ack) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic cpu_txn(input logic we, input logic [22:0] addr, input logic [7:0] din, output bit ok);
        a_we   = we;
        a_addr = addr;
        a_din  = din;
        a_req  = 1'b1;
        wait_ack(1'b0, ok);
        a_req  = 1'b0;
    endtask

    typedef struct {
        logic        we;
        logic [22:0] addr;
        logic [7:0]  din;
        logic [7:0]  rdata;
        logic [7:0]  exp_dout;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        bit seen;
        int base_ref, base_rw, base_idx;
        logic [7:0] order[4];
        int n_ord;
        string exp_order;

        resetn = 1'b0; ctl_force = 1'b0;
        a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_din = '0;
        b_req = 1'b0; b_addr = '0;
        mem8 = 8'h00; mem32 = 32'h0;

        // Reset values
        repeat (2) @(negedge clk);
        check("reset_ctrl_outputs", {a_ack, b_ack, sd_rd, sd_wr, sd_refresh, sd_addr, sd_din}, 64'h0);
        check("reset_data_outputs", {a_dout, b_dout}, 64'h0);

        // Wrap coinciding with a refresh grant keeps the next refresh pending
        ctl_force = 1'b1;
        do_reset();
        repeat (39) @(negedge clk);
        #1;
        check("coin_pending_before", dut.refresh_pending, 1);
        ctl_force = 1'b0;
        base_ref = n_ref;
        @(negedge clk);
        #1;
        check("coin_refresh_issue", sd_refresh, 1);
        check("coin_pending_kept", dut.refresh_pending, 1);
        repeat (18) @(negedge clk);
        #1;
        check("coin_ref_count", n_ref - base_ref, 2);

        // Controller busy through initialisation with a CPU read waiting
        mem8 = 8'h99; ctl_force = 1'b1;
        a_we = 1'b0; a_addr = 23'h000055; a_req = 1'b1;
        do_reset();
        base_ref = n_ref; base_rw = n_rd + n_wr; base_idx = cmd_log.size();
        repeat (10000) @(negedge clk);
        #1;
        check("init_no_rw", (n_rd + n_wr) - base_rw, 0);
        check("init_no_refresh", n_ref - base_ref, 0);
        check("init_pending", dut.refresh_pending, 1);
        ctl_force = 1'b0;
        wait_ack(1'b0, ok);
        a_req = 1'b0;
        check("init_ack_seen", ok, 1);
        check("init_first_cmd_refresh", cmd_log[base_idx], 3);
        check("init_second_cmd_read", cmd_log[base_idx + 1], 1);
        check("init_read_data", a_dout, 8'h99);

        // Both ports requesting continuously
        do_reset();
        a_we = 1'b0; a_addr = 23'h000010; b_addr = 23'h000020;
        a_req = 1'b1; b_req = 1'b1;
        n_ord = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (a_ack) begin order[n_ord] = "A"; n_ord++; end
            else if (b_ack) begin order[n_ord] = "B"; n_ord++; end
            if (n_ord == 4) break;
        end
        a_req = 1'b0; b_req = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        exp_order = "BABA";
`else
        exp_order = "BBBB";
`endif
        check("arb_ack_count", n_ord, 4);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("arb_order_%0d", k), order[k], exp_order[k]);
        end

        // CPU transaction table
        vecs[0] = '{we: 1'b1, addr: 23'h000123, din: 8'hA5, rdata: 8'h00, exp_dout: 8'h00};
        vecs[1] = '{we: 1'b0, addr: 23'h000123, din: 8'h00, rdata: 8'hA5, exp_dout: 8'hA5};
        vecs[2] = '{we: 1'b1, addr: 23'h7FFFFF, din: 8'h3C, rdata: 8'h11, exp_dout: 8'hA5};
        vecs[3] = '{we: 1'b0, addr: 23'h7FFFFF, din: 8'hEE, rdata: 8'h3C, exp_dout: 8'h3C};
        vecs[4] = '{we: 1'b0, addr: 23'h000000, din: 8'h00, rdata: 8'h5A, exp_dout: 8'h5A};
        vecs[5] = '{we: 1'b1, addr: 23'h000000, din: 8'hFF, rdata: 8'h22, exp_dout: 8'h5A};
        do_reset();
        for (int v = 0; v < 6; v++) begin
            mem8 = vecs[v].rdata;
            cpu_txn(vecs[v].we, vecs[v].addr, vecs[v].din, ok);
            check($sformatf("v%0d_ack", v), ok, 1);
            check($sformatf("v%0d_kind", v), last_rw_kind, vecs[v].we ? 2 : 1);
            check($sformatf("v%0d_addr", v), rw_addr, vecs[v].addr);
            if (vecs[v].we) check($sformatf("v%0d_din", v), wr_din, vecs[v].din);
            check($sformatf("v%0d_dout_at_ack", v), a_dout, vecs[v].exp_dout);
            mem8 = ~vecs[v].rdata;
            @(negedge clk);
            check($sformatf("v%0d_ack_one_cycle", v), a_ack, 0);
            check($sformatf("v%0d_dout_held", v), a_dout, vecs[v].exp_dout);
        end

        // Video read leaves the CPU data alone
        mem32 = 32'hDEADBEEF; mem8 = 8'h77;
        b_addr = 23'h400000; b_req = 1'b1;
        wait_ack(1'b1, ok);
        b_req = 1'b0;
        check("vid_ack", ok, 1);
        check("vid_kind", last_rw_kind, 1);
        check("vid_addr", rw_addr, 23'h400000);
        check("vid_dout", b_dout, 32'hDEADBEEF);
        check("vid_a_dout_unchanged", a_dout, 8'h5A);
        mem32 = 32'h0;
        @(negedge clk);
        check("vid_ack_one_cycle", b_ack, 0);
        check("vid_dout_held", b_dout, 32'hDEADBEEF);

        // Reset in the middle of a read abandons it without an ack
        mem8 = 8'hC3; a_we = 1'b0; a_addr = 23'h000001; a_req = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (sd_rd) begin seen = 1'b1; break; end
        end
        check("midrst_read_issued", seen, 1);
        repeat (2) @(negedge clk);
        resetn = 1'b0; a_req = 1'b0;
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (a_ack) seen = 1'b1;
        end
        check("midrst_outputs_zero", {a_ack, b_ack, sd_rd, sd_wr, sd_refresh, sd_addr, sd_din, a_dout}, 64'h0);
        resetn = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (a_ack) seen = 1'b1;
        end
        check("midrst_no_ack", seen, 0);
        check("midrst_a_dout", a_dout, 8'h00);

        // Refresh rate over an idle window
        base_ref = n_ref;
        repeat (2000) @(negedge clk);
        #1;
        check("refresh_rate_ge_99", (n_ref - base_ref) >= 99, 1);
        check("protocol_violations", viol, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sdram_arbiter.md
SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 SHALL have parameter REFRESH_CYCLES, default 700, giving clk cycles between refresh requests (14.6 us at 48 MHz).
REQ-002 SHALL have port clk, input, 1, rising-edge system clock, shared with the SDRAM controller.
REQ-003 SHALL have port resetn, input, 1, synchronous active-low reset.
REQ-004 SHALL have port a_req, input, 1, CPU port request; a level held until a_ack.
REQ-005 SHALL have port a_we, input, 1, CPU write (1) or read (0).
REQ-006 SHALL have port a_addr, input, 23, CPU byte address.
REQ-007 SHALL have port a_din, input, 8, CPU write data.
REQ-008 SHALL have port a_ack, output, 1, one-cycle CPU completion pulse.
REQ-009 SHALL have port a_dout, output, 8, CPU read data, held until the next CPU read completes.
REQ-010 SHALL have port b_req, input, 1, video port read request; a level held until b_ack.
REQ-011 SHALL have port b_addr, input, 23, video byte address.
REQ-012 SHALL have port b_ack, output, 1, one-cycle video completion pulse.
REQ-013 SHALL have port b_dout, output, 32, video read word, held until the next video read completes.
REQ-014 SHALL have ports sd_rd, sd_wr and sd_refresh, output, 1 each, command pulses to the controller.
REQ-015 SHALL have ports sd_addr (output, 23) and sd_din (output, 8), carrying the command address and write data.
REQ-016 SHALL have ports sd_dout (input, 8), sd_dout32 (input, 32), sd_data_ready (input, 1) and sd_busy (input, 1), driven by the controller.

Function
REQ-017 SHALL implement the states IDLE, ISSUE, WAIT_BUSY and WAIT_DONE.
REQ-018 SHALL grant in IDLE only when sd_busy=0, by priority refresh_pending > b_req > a_req, and then enter ISSUE.
REQ-019 SHALL latch sd_addr, sd_din and the grant owner at grant, with sd_addr = a_addr or b_addr and sd_din = a_din.
REQ-020 SHALL assert exactly one of sd_rd, sd_wr or sd_refresh for exactly one cycle in ISSUE, then enter WAIT_BUSY.
REQ-021 SHALL enter WAIT_DONE from WAIT_BUSY on sd_busy=1.
REQ-022 SHALL return to IDLE from WAIT_DONE on sd_busy=0, pulsing the owner's ack in that same cycle; a refresh produces no ack.
REQ-023 SHALL capture data in WAIT_DONE when sd_data_ready=1: sd_dout into a_dout for CPU reads, sd_dout32 into b_dout for video reads.
REQ-024 SHALL drive sd_wr only for a CPU grant with a_we=1; video grants are always reads.
REQ-025 SHALL run a refresh counter from 0 to REFRESH_CYCLES-1 and wrap, setting refresh_pending at the wrap.
REQ-026 SHALL clear refresh_pending on a refresh grant.
REQ-027 SHALL leave refresh_pending at 1, with no second refresh queued, when a wrap occurs while it is already set.
REQ-028 SHALL, when a wrap and a refresh grant coincide, leave refresh_pending at 1.
REQ-029 SHALL issue nothing while sd_busy=1 in IDLE, covering controller initialisation; refresh_pending still accumulates.
REQ-030 SHALL NOT use a dropped req before its ack; the requester must hold req and its inputs stable until ack.
REQ-031 SHALL NOT grant the same port on the cycle its ack pulses; a req held high after ack is re-granted no earlier than the next cycle.

Reset
REQ-032 SHALL, when resetn=0, set state IDLE, refresh counter 0 and refresh_pending 0.
REQ-033 SHALL, when resetn=0, set all outputs to 0: a_ack, b_ack, sd_rd, sd_wr, sd_refresh, sd_addr, sd_din, a_dout and b_dout.
REQ-034 SHALL abandon any in-flight transaction on reset without an ack.

Configuration
REQ-035 SHALL, with ARB_ROUND_ROBIN_EN defined, order CPU and video priority when both request by a last-served bit: the port not served last wins; the bit resets to CPU-last, so video wins first.
REQ-036 SHALL, without ARB_ROUND_ROBIN_EN, use fixed priority b_req > a_req.
REQ-037 SHALL give refresh top priority in both builds.

Verification
REQ-038 SHALL pass this scenario: sd_busy held 1 for 10000 cycles after reset → no sd_rd/sd_wr, sd_refresh first pulses after sd_busy falls, refresh_pending=1 beforehand.
REQ-039 SHALL pass this scenario: CPU write a_addr=0x000123, a_din=0xA5 → sd_wr one cycle with sd_addr=0x000123, sd_din=0xA5; a_ack pulse the cycle sd_busy falls.
REQ-040 SHALL pass this scenario: CPU read of 0x000123 with controller model returning sd_dout=0xA5 on sd_data_ready → a_dout=0xA5 at a_ack and held afterwards.
REQ-041 SHALL pass this scenario: video read b_addr=0x400000 with sd_dout32=0xDEADBEEF → b_dout=0xDEADBEEF, b_ack one pulse, a_dout unchanged.
REQ-042 SHALL pass this scenario: a_req and b_req asserted together for 4 transactions → fixed build yields B,B,B,B before A; ARB_ROUND_ROBIN_EN build yields B,A,B,A.
REQ-043 SHALL pass this scenario: refresh wrap coinciding with pending a_req, REFRESH_CYCLES=20 → sd_refresh issued first, then sd_rd; over 2000 cycles the refresh count is ≥99.
